// File: rtl/cdc_event_arbiter.sv
// cdc_event_arbiter
// Serializes single-cycle event pulses from NUM_REQ requesters onto one
// level/ack event line that feeds a CDC handshake synchronizer. Each granted
// event drives sync_data high for HOLD_CYCLES. A GAP_CYCLES low recovery
// period then follows. Grants are round-robin over latched pending events.
//
// Optional feature macro: CDC_ARB_OVERFLOW_EN (sticky lost-event flags).
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   req_pulse     one-cycle event pulses, one bit per requester
//   clr_overflow  clears all overflow flags (ignored when the feature is off)
//   sync_data     event level to the synchronizer data input
//   sync_id       index of the requester currently or last granted
//   pending       latched events not yet granted
//   busy          high whenever the arbiter is not idle
//   overflow      sticky per-requester lost-event flags
module cdc_event_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ID_W        = 2,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_pulse,
    input  logic               clr_overflow,
    output logic               sync_data,
    output logic [ID_W-1:0]    sync_id,
    output logic [NUM_REQ-1:0] pending,
    output logic               busy,
    output logic [NUM_REQ-1:0] overflow
);

    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   last_next;
    logic               data_next;
    logic [ID_W-1:0]    id_next;
    logic [NUM_REQ-1:0] pending_next;
    logic [NUM_REQ-1:0] overflow_next;
    logic [NUM_REQ-1:0] grant_mask;
    logic               busy_next;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;

    // Round-robin pick: first registered pending bit after last_grant, wrapping.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin : scan
            int unsigned cand;
            cand = (32'(last_grant) + k) % NUM_REQ;
            if (!win_valid && pending[IDX_W'(cand)]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    // State register plus registered outputs; reset parks in GAP so an
    // in-flight synchronizer request can drain before the first new event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= GAP;
            cnt        <= GAP_LOAD;
            last_grant <= LAST_RST;
            sync_data  <= 1'b0;
            sync_id    <= '0;
            pending    <= '0;
            overflow   <= '0;
            busy       <= 1'b1;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            last_grant <= last_next;
            sync_data  <= data_next;
            sync_id    <= id_next;
            pending    <= pending_next;
            overflow   <= overflow_next;
            busy       <= busy_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (win_valid) state_next = HOLD;
            HOLD:    if (cnt == '0) state_next = GAP;
            GAP:     if (cnt == '0) state_next = IDLE;
            default: state_next = GAP;
        endcase
    end

    // Next values of counter, grant bookkeeping and registered outputs.
    always_comb begin
        cnt_next   = cnt;
        last_next  = last_grant;
        data_next  = sync_data;
        id_next    = sync_id;
        grant_mask = '0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    data_next  = 1'b1;
                    id_next    = ID_W'(win_idx);
                    last_next  = win_idx;
                    cnt_next   = HOLD_LOAD;
                    grant_mask = NUM_REQ'(1) << win_idx;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    data_next = 1'b0;
                    cnt_next  = GAP_LOAD;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt != '0) cnt_next = cnt - CNT_W'(1);
            end
            default: begin
                data_next = 1'b0;
                cnt_next  = GAP_LOAD;
            end
        endcase

        // A pulse on the grant edge survives as a fresh event.
        pending_next = (pending & ~grant_mask) | req_pulse;
        busy_next    = (state_next != IDLE);
    end

`ifdef CDC_ARB_OVERFLOW_EN
    logic [NUM_REQ-1:0] ovf_set;

    // A repeat pulse on a still-pending, not-now-granted requester is lost.
    always_comb begin
        ovf_set       = req_pulse & pending & ~grant_mask;
        overflow_next = clr_overflow ? ovf_set : (overflow | ovf_set);
    end
`else
    logic unused_clr;

    assign unused_clr    = clr_overflow;
    assign overflow_next = '0;
`endif

endmodule

// File: tb/tb_cdc_event_arbiter.sv
module tb_cdc_event_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned HOLD    = 4;
    localparam int unsigned GAP     = 8;
    localparam int unsigned PERIOD  = HOLD + GAP + 1;

`ifdef CDC_ARB_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NUM_REQ-1:0] req_pulse = '0;
    logic               clr_overflow = 1'b0;
    logic               sync_data;
    logic [ID_W-1:0]    sync_id;
    logic [NUM_REQ-1:0] pending;
    logic               busy;
    logic [NUM_REQ-1:0] overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: time since the last grant decides everything timing-wise.
    logic [NUM_REQ-1:0] m_pending = '0;
    logic [NUM_REQ-1:0] m_ovf     = '0;
    int                 m_last    = NUM_REQ - 1;
    int                 m_since   = HOLD;
    int                 m_id      = 0;

    always #5 clk = ~clk;

    cdc_event_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ID_W        (ID_W),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_pulse    (req_pulse),
        .clr_overflow (clr_overflow),
        .sync_data    (sync_data),
        .sync_id      (sync_id),
        .pending      (pending),
        .busy         (busy),
        .overflow     (overflow)
    );

    function automatic void model_edge(input logic [NUM_REQ-1:0] req, input logic clr,
                                       input logic rst);
        int g;
        int idx;
        logic [NUM_REQ-1:0] gm;
        logic [NUM_REQ-1:0] set;
        if (!rst) begin
            m_pending = '0;
            m_ovf     = '0;
            m_last    = NUM_REQ - 1;
            m_since   = HOLD;
            m_id      = 0;
            return;
        end
        g  = -1;
        gm = '0;
        if (m_since >= int'(HOLD + GAP) && m_pending != '0) begin
            for (int k = 1; k <= int'(NUM_REQ); k++) begin
                idx = (m_last + k) % NUM_REQ;
                if (g < 0 && m_pending[2'(idx)]) g = idx;
            end
        end
        if (g >= 0) begin
            gm[2'(g)] = 1'b1;
            m_since   = 0;
            m_id      = g;
            m_last    = g;
        end else if (m_since < int'(HOLD + GAP)) begin
            m_since++;
        end
        if (OVF_EN) begin
            set   = req & m_pending & ~gm;
            m_ovf = clr ? set : (m_ovf | set);
        end
        m_pending = (m_pending & ~gm) | req;
    endfunction

    task automatic tick(input logic [NUM_REQ-1:0] req, input logic clr);
        req_pulse    = req;
        clr_overflow = clr;
        @(posedge clk);
        #1;
        model_edge(req, clr, rst_n);
        req_pulse    = '0;
        clr_overflow = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy !== 1'b0; i++) tick('0, 1'b0);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_timeout: busy=%b required 0", busy);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick('0, 1'b0);
        tick('0, 1'b0);
        rst_n = 1'b1;
        wait_idle();
    endtask

    task automatic test_reset();
        int  cyc;
        bit  done;
        int  data_hi;
        rst_n = 1'b0;
        tick(4'b1111, 1'b1);
        tick(4'b0101, 1'b0);
        tick(4'b1010, 1'b0);
        n_tests += 5;
        if (sync_data !== 1'b0) begin n_fail++; $display("FAIL reset_sync_data: got %b required 0", sync_data); end
        if (sync_id !== 2'd0) begin n_fail++; $display("FAIL reset_sync_id: got %0d required 0", sync_id); end
        if (pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending: got %b required 0000", pending); end
        if (overflow !== 4'b0000) begin n_fail++; $display("FAIL reset_overflow: got %b required 0000", overflow); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b required 1", busy); end
        rst_n   = 1'b1;
        cyc     = -1;
        done    = 1'b0;
        data_hi = 0;
        for (int i = 1; i <= 30 && !done; i++) begin
            tick('0, 1'b0);
            if (sync_data === 1'b1) data_hi++;
            if (busy === 1'b0) begin
                cyc  = i;
                done = 1'b1;
            end
        end
        n_tests += 2;
        if (cyc != int'(GAP)) begin n_fail++; $display("FAIL reset_busy_fall: got %0d cycles required %0d", cyc, GAP); end
        if (data_hi != 0) begin n_fail++; $display("FAIL reset_gap_quiet: got %0d high cycles required 0", data_hi); end
    endtask

    task automatic test_single();
        int high;
        int id_bad;
        bit done;
        do_reset();
        tick(4'b0100, 1'b0);
        n_tests += 2;
        if (sync_data !== 1'b0) begin n_fail++; $display("FAIL single_latch_data: got %b required 0", sync_data); end
        if (pending !== 4'b0100) begin n_fail++; $display("FAIL single_latch_pending: got %b required 0100", pending); end
        tick('0, 1'b0);
        n_tests += 3;
        if (sync_data !== 1'b1) begin n_fail++; $display("FAIL single_rise: got %b required 1", sync_data); end
        if (sync_id !== 2'd2) begin n_fail++; $display("FAIL single_id: got %0d required 2", sync_id); end
        if (pending !== 4'b0000) begin n_fail++; $display("FAIL single_pending_clear: got %b required 0000", pending); end
        high   = 1;
        id_bad = 0;
        done   = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick('0, 1'b0);
            if (sync_data === 1'b1) begin
                high++;
                if (sync_id !== 2'd2) id_bad++;
            end else begin
                done = 1'b1;
            end
        end
        n_tests += 2;
        if (high != int'(HOLD)) begin n_fail++; $display("FAIL single_hold_len: got %0d required %0d", high, HOLD); end
        if (id_bad != 0) begin n_fail++; $display("FAIL single_id_stable: got %0d bad samples required 0", id_bad); end
        wait_idle();
    endtask

    task automatic test_simultaneous();
        int rise_t[$];
        int rise_id[$];
        int exp_id[3];
        logic prev;
        int held_id;
        int unstable;
        exp_id   = '{0, 1, 3};
        unstable = 0;
        held_id  = 0;
        do_reset();
        tick(4'b1011, 1'b0);
        prev = sync_data;
        for (int t = 1; t <= 50; t++) begin
            tick('0, 1'b0);
            if (sync_data === 1'b1 && prev !== 1'b1) begin
                rise_t.push_back(t);
                rise_id.push_back(int'(sync_id));
                held_id = int'(sync_id);
            end else if (sync_data === 1'b1 && int'(sync_id) != held_id) begin
                unstable++;
            end
            prev = sync_data;
        end
        n_tests++;
        if (rise_t.size() != 3) begin n_fail++; $display("FAIL simul_count: got %0d rises required 3", rise_t.size()); end
        for (int i = 0; i < 3 && i < rise_id.size(); i++) begin
            n_tests++;
            if (rise_id[i] != exp_id[i]) begin
                n_fail++;
                $display("FAIL simul_order[%0d]: got id %0d required %0d", i, rise_id[i], exp_id[i]);
            end
        end
        for (int i = 1; i < rise_t.size(); i++) begin
            n_tests++;
            if (rise_t[i] - rise_t[i-1] != int'(PERIOD)) begin
                n_fail++;
                $display("FAIL simul_spacing[%0d]: got %0d required %0d", i, rise_t[i] - rise_t[i-1], PERIOD);
            end
        end
        n_tests++;
        if (unstable != 0) begin n_fail++; $display("FAIL simul_id_stable: got %0d changes required 0", unstable); end
        wait_idle();
    endtask

    task automatic test_fairness();
        int rise_id[$];
        int exp_id[4];
        int repeats;
        logic prev;
        exp_id = '{0, 2, 0, 2};
        do_reset();
        prev = sync_data;
        for (int t = 0; t < 60; t++) begin
            tick((t < 45) ? 4'b0101 : 4'b0000, 1'b0);
            if (sync_data === 1'b1 && prev !== 1'b1) rise_id.push_back(int'(sync_id));
            prev = sync_data;
        end
        n_tests++;
        if (rise_id.size() < 4) begin n_fail++; $display("FAIL fair_count: got %0d rises required >=4", rise_id.size()); end
        for (int i = 0; i < 4 && i < rise_id.size(); i++) begin
            n_tests++;
            if (rise_id[i] != exp_id[i]) begin
                n_fail++;
                $display("FAIL fair_order[%0d]: got id %0d required %0d", i, rise_id[i], exp_id[i]);
            end
        end
        repeats = 0;
        for (int i = 1; i < rise_id.size(); i++) if (rise_id[i] == 0 && rise_id[i-1] == 0) repeats++;
        n_tests++;
        if (repeats != 0) begin n_fail++; $display("FAIL fair_no_repeat: got %0d repeats required 0", repeats); end
        wait_idle();
    endtask

    task automatic test_overflow();
        int   ev1;
        logic prev;
        logic [NUM_REQ-1:0] exp_ovf;
        exp_ovf = OVF_EN ? 4'b0010 : 4'b0000;
        do_reset();
        tick(4'b0001, 1'b0);
        tick(4'b0010, 1'b0);
        tick(4'b0010, 1'b0);
        n_tests += 2;
        if (overflow !== exp_ovf) begin n_fail++; $display("FAIL ovf_set: got %b required %b", overflow, exp_ovf); end
        if (pending !== 4'b0010) begin n_fail++; $display("FAIL ovf_pending: got %b required 0010", pending); end
        ev1  = 0;
        prev = sync_data;
        for (int t = 0; t < 40; t++) begin
            tick('0, 1'b0);
            if (sync_data === 1'b1 && prev !== 1'b1 && sync_id === 2'd1) ev1++;
            prev = sync_data;
        end
        n_tests += 2;
        if (ev1 != 1) begin n_fail++; $display("FAIL ovf_merge: got %0d events required 1", ev1); end
        if (overflow !== exp_ovf) begin n_fail++; $display("FAIL ovf_sticky: got %b required %b", overflow, exp_ovf); end
        wait_idle();
        tick('0, 1'b1);
        n_tests++;
        if (overflow !== 4'b0000) begin n_fail++; $display("FAIL ovf_clear: got %b required 0000", overflow); end
        tick(4'b0001, 1'b0);
        tick(4'b0010, 1'b0);
        tick(4'b0010, 1'b1);
        n_tests++;
        if (overflow !== exp_ovf) begin n_fail++; $display("FAIL ovf_set_beats_clr: got %b required %b", overflow, exp_ovf); end
        tick('0, 1'b1);
        wait_idle();
    endtask

    task automatic test_midreset();
        int   n;
        int   rise_at;
        logic prev;
        do_reset();
        tick(4'b0100, 1'b0);
        tick(4'b1000, 1'b0);
        n_tests++;
        if (sync_data !== 1'b1) begin n_fail++; $display("FAIL midrst_in_hold: got %b required 1", sync_data); end
        rst_n = 1'b0;
        tick('0, 1'b0);
        n_tests += 4;
        if (sync_data !== 1'b0) begin n_fail++; $display("FAIL midrst_data: got %b required 0", sync_data); end
        if (pending !== 4'b0000) begin n_fail++; $display("FAIL midrst_pending: got %b required 0000", pending); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy: got %b required 1", busy); end
        if (sync_id !== 2'd0) begin n_fail++; $display("FAIL midrst_id: got %0d required 0", sync_id); end
        rst_n = 1'b1;
        tick(4'b0001, 1'b0);
        n       = 1;
        rise_at = -1;
        prev    = sync_data;
        for (int i = 0; i < 30 && rise_at < 0; i++) begin
            tick('0, 1'b0);
            n++;
            if (sync_data === 1'b1 && prev !== 1'b1) rise_at = n;
            prev = sync_data;
        end
        n_tests++;
        if (rise_at != int'(GAP + 1)) begin n_fail++; $display("FAIL midrst_first_rise: got edge %0d required %0d", rise_at, GAP + 1); end
        wait_idle();
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] req;
        logic clr;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            for (int b = 0; b < int'(NUM_REQ); b++) req[2'(b)] = ($urandom_range(0, 7) == 0);
            clr = ($urandom_range(0, 15) == 0);
            tick(req, clr);
            n_tests += 5;
            if (sync_data !== (m_since < int'(HOLD))) begin
                n_fail++; $display("FAIL rand_sync_data @%0d: got %b required %b", c, sync_data, m_since < int'(HOLD));
            end
            if (sync_id !== ID_W'(m_id)) begin
                n_fail++; $display("FAIL rand_sync_id @%0d: got %0d required %0d", c, sync_id, m_id);
            end
            if (pending !== m_pending) begin
                n_fail++; $display("FAIL rand_pending @%0d: got %b required %b", c, pending, m_pending);
            end
            if (busy !== (m_since < int'(HOLD + GAP))) begin
                n_fail++; $display("FAIL rand_busy @%0d: got %b required %b", c, busy, m_since < int'(HOLD + GAP));
            end
            if (overflow !== m_ovf) begin
                n_fail++; $display("FAIL rand_overflow @%0d: got %b required %b", c, overflow, m_ovf);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_overflow();
        test_midreset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
